// File: rtl/led_pattern_gen.sv
// -----------------------------------------------------------------------------
// led_pattern_gen
//
// Multi-channel LED pattern generator for board status indication. A single
// free-running prescaler produces a one-cycle clock-enable tick; every channel
// advances its own pattern on that tick. No derived clocks are used.
//
// Each channel holds a mode (OFF, ON, BLINK, BURST) and a half-period in ticks,
// loaded through a one-cycle register write port. A write restarts the
// channel's pattern in its on-state.
//
// Optional feature macro: LED_PWM_DIM_EN
//   When defined, adds input dim[3:0] and a free-running 4-bit PWM counter
//   that gates all LED outputs (dim=15 full on, dim=0 is 1/16 duty).
//
// Ports
//   mclk       in   system clock
//   rs_n       in   asynchronous active-low reset
//   wr_en      in   one-cycle write strobe
//   wr_ch      in   target channel (writes to channels >= CHANNELS are ignored)
//   wr_mode    in   00 OFF, 01 ON, 10 BLINK, 11 BURST
//   wr_period  in   half-period in ticks (0 behaves as 1)
//   dim        in   brightness, only with LED_PWM_DIM_EN
//   led        out  registered LED drive, active-high
// -----------------------------------------------------------------------------
module led_pattern_gen #(
   parameter int CHANNELS = 4,
   parameter int PRESCALE = 50000,
   parameter int PER_W    = 10,
   parameter int BURST_N  = 3,
   parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                mclk,
   input  logic                rs_n,
   input  logic                wr_en,
   input  logic [CH_W-1:0]     wr_ch,
   input  logic [1:0]          wr_mode,
   input  logic [PER_W-1:0]    wr_period,
`ifdef LED_PWM_DIM_EN
   input  logic [3:0]          dim,
`endif
   output logic [CHANNELS-1:0] led
);

   localparam int              PS_W    = $clog2(PRESCALE);
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
   localparam int              H_N     = 4 * BURST_N;
   localparam int              H_W     = $clog2(H_N);
   localparam logic [H_W-1:0]  H_LAST  = H_W'(H_N - 1);

   localparam logic [1:0] M_OFF   = 2'b00;
   localparam logic [1:0] M_ON    = 2'b01;
   localparam logic [1:0] M_BLINK = 2'b10;
   localparam logic [1:0] M_BURST = 2'b11;

   logic [PS_W-1:0]     pre_cnt;
   logic                tick;

   logic [1:0]          mode   [CHANNELS];
   logic [PER_W-1:0]    period [CHANNELS];
   logic [PER_W-1:0]    cnt    [CHANNELS];
   logic [H_W-1:0]      hidx   [CHANNELS];
   logic [CHANNELS-1:0] phase;

   logic [CHANNELS-1:0] wr_hit;
   logic [CHANNELS-1:0] at_last;
   logic [CHANNELS-1:0] run;
   logic [CHANNELS-1:0] raw;

   // ---- prescaler: free-running, never disturbed by writes ----
   always_ff @(posedge mclk or negedge rs_n) begin
      if (!rs_n)
         pre_cnt <= '0;
      else if (pre_cnt == PS_LAST)
         pre_cnt <= '0;
      else
         pre_cnt <= pre_cnt + PS_W'(1);
   end

   assign tick = (pre_cnt == PS_LAST);

   // ---- per-channel decode ----
   always_comb begin
      wr_hit  = '0;
      at_last = '0;
      run     = '0;
      raw     = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         // Out-of-range channel numbers never match any index, so such writes
         // leave every channel untouched.
         wr_hit[i]  = wr_en && (int'(wr_ch) == i);
         // A programmed period of 0 behaves as 1.
         at_last[i] = (period[i] <= PER_W'(1)) ? (cnt[i] == '0)
                                                : (cnt[i] == period[i] - PER_W'(1));
         run[i]     = mode[i][1];
         case (mode[i])
            M_OFF:   raw[i] = 1'b0;
            M_ON:    raw[i] = 1'b1;
            M_BLINK: raw[i] = phase[i];
            M_BURST: raw[i] = (int'(hidx[i]) < 2 * BURST_N) && !hidx[i][0];
         endcase
      end
   end

   // ---- channel state registers ----
   always_ff @(posedge mclk or negedge rs_n) begin
      if (!rs_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            mode[i]   <= M_OFF;
            period[i] <= '0;
            cnt[i]    <= '0;
            hidx[i]   <= '0;
         end
         phase <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            // A write in a tick cycle wins; that channel drops the tick.
            if (wr_hit[i]) begin
               mode[i]   <= wr_mode;
               period[i] <= wr_period;
               cnt[i]    <= '0;
               hidx[i]   <= '0;
               phase[i]  <= 1'b1;
            end else if (tick && run[i]) begin
               if (at_last[i]) begin
                  cnt[i]   <= '0;
                  phase[i] <= ~phase[i];
                  hidx[i]  <= (hidx[i] == H_LAST) ? '0 : hidx[i] + H_W'(1);
               end else begin
                  cnt[i] <= cnt[i] + PER_W'(1);
               end
            end
         end
      end
   end

   // ---- output register ----
`ifdef LED_PWM_DIM_EN
   logic [3:0] pwm_cnt;

   always_ff @(posedge mclk or negedge rs_n) begin
      if (!rs_n)
         pwm_cnt <= '0;
      else
         pwm_cnt <= pwm_cnt + 4'd1;
   end

   always_ff @(posedge mclk or negedge rs_n) begin
      if (!rs_n)
         led <= '0;
      else
         led <= raw & {CHANNELS{pwm_cnt <= dim}};
   end
`else
   always_ff @(posedge mclk or negedge rs_n) begin
      if (!rs_n)
         led <= '0;
      else
         led <= raw;
   end
`endif

endmodule
